// File: rtl/ram_stream_reader.sv
// Streams a contiguous block RAM address range out on a valid/ready master.
// Ports: clk_i/rstn_i, start_i/start_address_i/length_i request, busy_o/done_o
// status, ram_rd_* to the RAM read port, m_* stream master.
module ram_stream_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     start_i,
  input  logic [ADDRESS_WIDTH-1:0] start_address_i,
  input  logic [ADDRESS_WIDTH:0]   length_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_address_o,
  output logic                     ram_rd_enable_o,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data_i,
  input  logic                     ram_rd_valid_i,
  output logic [DATA_WIDTH-1:0]    m_data_o,
  output logic                     m_valid_o,
  output logic                     m_last_o,
  input  logic                     m_ready_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDRESS_WIDTH:0]   ONE_R = 1;
  localparam logic [ADDRESS_WIDTH:0]   ZERO_R = '0;

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH:0]   r_remaining;
  logic                     r_inflight;
  logic                     r_last_d;
  logic                     r_done;
  logic [DATA_WIDTH-1:0]    r_fifo_data [2];
  logic [1:0]               r_fifo_last;
  logic                     r_wptr;
  logic                     r_rptr;
  logic [1:0]               r_count;

  logic w_pop;
  logic w_wr;
  logic w_issue;
  logic w_issue_last;
  logic w_start_go;
  logic w_start_zero;
  logic w_end;

  assign m_valid_o = (r_count != 2'd0);
  assign m_data_o  = r_fifo_data[r_rptr];
  assign m_last_o  = r_fifo_last[r_rptr];
  assign w_pop     = m_valid_o && m_ready_i;

  // Credit: buffered + in flight - leaving this cycle must stay below 2.
  assign w_issue = (r_state == S_READ) &&
    (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_issue_last = w_issue && (r_remaining == ONE_R);

  // Capture only responses to reads issued since reset, dropping stale ones.
  assign w_wr = ram_rd_valid_i && r_inflight;

  assign w_start_go   = (r_state == S_IDLE) && start_i && (length_i != ZERO_R);
  assign w_start_zero = (r_state == S_IDLE) && start_i && (length_i == ZERO_R);
  assign w_end        = (r_state == S_DRAIN) && w_pop && m_last_o;

  assign ram_rd_enable_o  = w_issue;
  assign ram_rd_address_o = r_addr;
  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = r_done;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_last_d    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_last_d   <= w_issue_last;
      r_done     <= w_start_zero || w_end;
      unique case (r_state)
        S_IDLE: begin
          if (w_start_go) begin
            r_addr      <= start_address_i;
            r_remaining <= length_i;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_addr      <= r_addr + ONE_A;
            r_remaining <= r_remaining - ONE_R;
            if (w_issue_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_end) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= 2'b00;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_wr) begin
        r_fifo_data[r_wptr] <= ram_rd_data_i;
        r_fifo_last[r_wptr] <= r_last_d;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      if (w_wr && !w_pop)      r_count <= r_count + 2'd1;
      else if (!w_wr && w_pop) r_count <= r_count - 2'd1;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(w_wr && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle-latency RAM model.
// Checks stream order, last/done timing, wrap, backpressure and reset.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] start_address_i = '0;
  logic [8:0] length_i = '0;
  logic       busy_o;
  logic       done_o;
  logic [7:0] ram_rd_address_o;
  logic       ram_rd_enable_o;
  logic [7:0] ram_rd_data_i = '0;
  logic       ram_rd_valid_i = 1'b0;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_last_o;
  logic       m_ready_i = 1'b0;

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;

  logic [8:0] beats [$];
  logic [7:0] rd_addrs [$];
  int  first_cyc, last_cyc, done_cyc, n_done, n_rd, outst, max_out;
  bit  any_en, any_valid, any_busy, done_busy;
  bit  p_stall;
  logic [7:0] p_data;
  logic p_last;
  int  c0;

  ram_stream_reader #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i),
    .start_address_i(start_address_i), .length_i(length_i),
    .busy_o(busy_o), .done_o(done_o),
    .ram_rd_address_o(ram_rd_address_o),
    .ram_rd_enable_o(ram_rd_enable_o),
    .ram_rd_data_i(ram_rd_data_i), .ram_rd_valid_i(ram_rd_valid_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rd_valid_i <= ram_rd_enable_o;
    ram_rd_data_i  <= mem[ram_rd_address_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    beats.delete();
    rd_addrs.delete();
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    n_done = 0; n_rd = 0; outst = 0; max_out = 0;
    any_en = 0; any_valid = 0; any_busy = 0; done_busy = 0;
    p_stall = 0;
  endtask

  // One cycle: sample at negedge, then advance past the next posedge.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    if (ram_rd_enable_o) begin
      n_rd++;
      rd_addrs.push_back(ram_rd_address_o);
      any_en = 1;
    end
    if (m_valid_o) any_valid = 1;
    if (busy_o) any_busy = 1;
    if (p_stall) begin
      chk("stall_valid", {31'd0, m_valid_o}, 32'd1);
      chk("stall_data", {24'd0, m_data_o}, {24'd0, p_data});
      chk("stall_last", {31'd0, m_last_o}, {31'd0, p_last});
    end
    p_stall = m_valid_o && !m_ready_i;
    p_data  = m_data_o;
    p_last  = m_last_o;
    if (m_valid_o && m_ready_i) begin
      beats.push_back({m_last_o, m_data_o});
      if (first_cyc < 0) first_cyc = cycle;
      last_cyc = cycle;
    end
    if (done_o) begin
      n_done++;
      done_cyc  = cycle;
      done_busy = busy_o;
    end
    outst = outst + int'(ram_rd_enable_o) - int'(m_valid_o && m_ready_i);
    if (outst > max_out) max_out = outst;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; 1: 2-low/1-high; 2: ready high plus stray starts.
  task automatic xfer(input logic [7:0] a, input logic [8:0] n,
                      input int mode, input int budget, input int stop_at);
    clr();
    start_i = 1'b1;
    start_address_i = a;
    length_i = n;
    m_ready_i = (mode != 1);
    c0 = cycle + 1;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < budget && n_done == 0; i++) begin
      if (stop_at > 0 && beats.size() >= stop_at) break;
      m_ready_i = (mode == 1) ? ((i % 3) == 2) : 1'b1;
      if (mode == 2) begin
        start_i = ((i % 37) == 5);
        start_address_i = 8'h00;
        length_i = 9'd3;
      end
      cyc();
    end
    start_i = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = k[7:0];
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_valid", {31'd0, m_valid_o}, 0);
    chk("rst_last", {31'd0, m_last_o}, 0);
    chk("rst_data", {24'd0, m_data_o}, 0);
    chk("rst_en", {31'd0, ram_rd_enable_o}, 0);
    chk("rst_addr", {24'd0, ram_rd_address_o}, 0);
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // Basic: 0x10, len 4
    xfer(8'h10, 9'd4, 0, 40, 0);
    chk("t1_count", beats.size(), 4);
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      chk("t1_data", {24'd0, beats[i][7:0]}, 32'h10 + i);
      chk("t1_last", {31'd0, beats[i][8]}, (i == 3) ? 1 : 0);
    end
    chk("t1_first_lat", first_cyc - c0, 3);
    chk("t1_thru", last_cyc - first_cyc, 3);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_done_cyc", done_cyc - last_cyc, 1);
    chk("t1_done_busy", {31'd0, done_busy}, 0);
    chk("t1_busy_seen", {31'd0, any_busy}, 1);
    chk("t1_reads", n_rd, 4);
    repeat (2) cyc();

    // Wrap: 0xFE, len 4
    xfer(8'hFE, 9'd4, 0, 40, 0);
    chk("t2_count", beats.size(), 4);
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      chk("t2_data", {24'd0, beats[i][7:0]}, (32'hFE + i) & 32'hFF);
      chk("t2_raddr", {24'd0, rd_addrs[i]}, (32'hFE + i) & 32'hFF);
    end
    chk("t2_reads", n_rd, 4);
    chk("t2_done", n_done, 1);
    repeat (2) cyc();

    // Backpressure: 0x40, len 8, ready 2-low/1-high
    xfer(8'h40, 9'd8, 1, 120, 0);
    chk("t3_count", beats.size(), 8);
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      chk("t3_data", {24'd0, beats[i][7:0]}, 32'h40 + i);
      chk("t3_last", {31'd0, beats[i][8]}, (i == 7) ? 1 : 0);
    end
    chk("t3_max_outst", {31'd0, max_out <= 2}, 1);
    chk("t3_reads", n_rd, 8);
    chk("t3_done", n_done, 1);
    m_ready_i = 1'b1;
    repeat (2) cyc();

    // Zero length
    xfer(8'h33, 9'd0, 0, 6, 0);
    repeat (3) cyc();
    chk("t4_done_cnt", n_done, 1);
    chk("t4_done_cyc", done_cyc - c0, 1);
    chk("t4_en", {31'd0, any_en}, 0);
    chk("t4_valid", {31'd0, any_valid}, 0);
    chk("t4_busy", {31'd0, any_busy}, 0);

    // Full range from 0x80 with stray starts while busy
    xfer(8'h80, 9'h100, 2, 400, 0);
    chk("t5_count", beats.size(), 256);
    for (int i = 0; i < 256 && i < beats.size(); i++)
      chk("t5_data", {24'd0, beats[i][7:0]}, (32'h80 + i) & 32'hFF);
    chk("t5_last", {31'd0, beats[beats.size()-1][8]}, 1);
    chk("t5_reads", n_rd, 256);
    chk("t5_done", n_done, 1);
    repeat (2) cyc();

    // Reset mid-transfer after the 3rd beat
    xfer(8'h20, 9'd8, 0, 40, 3);
    chk("t6_pre_beats", beats.size(), 3);
    rstn_i = 1'b0;
    #1;
    chk("t6_busy", {31'd0, busy_o}, 0);
    chk("t6_done", {31'd0, done_o}, 0);
    chk("t6_valid", {31'd0, m_valid_o}, 0);
    chk("t6_last", {31'd0, m_last_o}, 0);
    chk("t6_data", {24'd0, m_data_o}, 0);
    chk("t6_en", {31'd0, ram_rd_enable_o}, 0);
    chk("t6_addr", {24'd0, ram_rd_address_o}, 0);
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;
    clr();
    m_ready_i = 1'b1;
    repeat (4) cyc();
    chk("t6_stale_beats", beats.size(), 0);
    chk("t6_no_done", n_done, 0);
    chk("t6_idle_en", {31'd0, any_en}, 0);
    xfer(8'h00, 9'd2, 0, 40, 0);
    chk("t6_count", beats.size(), 2);
    for (int i = 0; i < 2 && i < beats.size(); i++) begin
      chk("t6_new_data", {24'd0, beats[i][7:0]}, i);
      chk("t6_new_last", {31'd0, beats[i][8]}, (i == 1) ? 1 : 0);
    end
    chk("t6_new_done", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
